ifetch_bridge: RTL and testbench
================================

IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 Parameter: CNT_W, 16, width of the miss counter output.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 rom_ce_i  in  1  core fetch enable (core pc_reg chip-enable).
REQ-005 rom_addr_i  in  32  core fetch byte address (core pc).
REQ-006 rom_data_o  out  32  instruction word returned to core (core rom_data_i).
REQ-007 stallreq_o  out  1  fetch-stall request to core pipeline control.
REQ-008 inval_i  in  1  invalidate cached word (fence or code write).
REQ-009 mem_req_o  out  1  instruction-memory read request.
REQ-010 mem_addr_o  out  32  word-aligned memory address.
REQ-011 mem_gnt_i  in  1  memory accepted request this cycle.
REQ-012 mem_rvalid_i  in  1  read data valid.
REQ-013 mem_rdata_i  in  32  read data.
REQ-014 miss_cnt_o  out  CNT_W  count of issued memory requests, saturating.

Function
REQ-015 State: FSM {IDLE, REQ, WAIT}; registers last_addr[31:2], last_data[31:0], last_valid, req_addr[31:2], discard, miss counter.
REQ-016 Word compare only: rom_addr_i[1:0] ignored; mem_addr_o = {req_addr, 2'b00}.
REQ-017 hit = rom_ce_i & last_valid & (rom_addr_i[31:2] == last_addr); combinational.
REQ-018 rom_ce_i=0: rom_data_o=0, stallreq_o=0; no request issued.
REQ-019 Hit: rom_data_o=last_data, stallreq_o=0, same cycle, in any state.
REQ-020 Bypass: state WAIT & mem_rvalid_i & rom_ce_i & rom_addr_i[31:2]==req_addr -> rom_data_o=mem_rdata_i, stallreq_o=0 that cycle.
REQ-021 Any other case with rom_ce_i=1: stallreq_o=1, rom_data_o=0.
REQ-022 IDLE, miss with rom_ce_i=1: latch req_addr=rom_addr_i[31:2], clear discard, increment miss counter, go REQ.
REQ-023 REQ: mem_req_o=1, mem_addr_o stable; mem_gnt_i=1 -> WAIT; mem_rvalid_i ignored in REQ and IDLE.
REQ-024 mem_req_o=0 in IDLE and WAIT; one outstanding request maximum.
REQ-025 WAIT: mem_rvalid_i=1 -> go IDLE; if discard=0 load last_addr=req_addr, last_data=mem_rdata_i, last_valid=1; if discard=1 cache unchanged.
REQ-026 Minimum miss latency: miss detected cycle N, gnt N+1, rvalid N+2 (bypass, stall drops), hit from N+3 onward.
REQ-027 Core address change while REQ/WAIT: outstanding request not cancelled; completes and fills cache; new address missed again from IDLE.
REQ-028 inval_i=1: clears last_valid next edge, all states; in REQ or WAIT also sets discard=1.
REQ-029 inval_i coincident with WAIT fill: discard wins; cache stays invalid; bypass still delivers data that cycle.
REQ-030 Miss counter saturates at 2^CNT_W-1; no wrap.
REQ-031 No combinational path from mem_gnt_i to mem_req_o.

Reset
REQ-032 rst=0 asynchronously forces: state IDLE, last_valid=0, last_addr=0, last_data=0, req_addr=0, discard=0, miss counter=0, mem_req_o=0.
REQ-033 Reset during REQ/WAIT abandons the transaction; later mem_rvalid_i in IDLE is ignored.
REQ-034 During reset rom_data_o=0; stallreq_o follows REQ-021 (1 if rom_ce_i=1).

Verification
REQ-035 Cold miss: addr 0x100, gnt at once, rvalid 0xDEADBEEF next cycle -> stall 2 cycles, bypass 0xDEADBEEF, miss_cnt=1, next cycle hit without stall.
REQ-036 Repeat 0x100/0x102 for 10 cycles after fill -> stallreq_o=0 throughout, miss_cnt unchanged, mem_req_o never set.
REQ-037 Gnt withheld 5 cycles -> mem_req_o and mem_addr_o=0x100 held 5 cycles, stall continuous.
REQ-038 Address 0x100 to 0x104 during WAIT -> 0x100 fills cache, then new request 0x104, miss_cnt=2.
REQ-039 inval_i in WAIT, rvalid 0x12345678 -> bypass that cycle, next cycle miss again (stall, new request).
REQ-040 rst low mid-WAIT, late rvalid after release -> cache invalid, miss_cnt=0, no state change from stray rvalid.

Source files
------------

// File: rtl/ifetch_bridge.sv
// Single-word instruction cache bridging core fetch to a req/gnt/rvalid memory port.
// Hits return the same cycle; a miss stalls the core until rvalid, with bypass on return.
module ifetch_bridge #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rom_ce_i,
  input  logic [31:0]      rom_addr_i,
  output logic [31:0]      rom_data_o,
  output logic             stallreq_o,
  input  logic             inval_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:2]      r_last_addr;
  logic [31:0]      r_last_data;
  logic             r_last_valid;
  logic [31:2]      r_req_addr;
  logic             r_discard;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_hit;
  logic             w_bypass;
  logic             w_latch;
  logic             w_resp;
  logic             w_fill;
  logic             w_busy;
  logic             w_cnt_sat;
  logic [1:0]       w_unused_addr_lsb;

  // Byte offset is irrelevant: the cache holds exactly one 32-bit word.
  assign w_unused_addr_lsb = rom_addr_i[1:0];

  assign w_hit    = rom_ce_i & r_last_valid & (rom_addr_i[31:2] == r_last_addr);
  assign w_bypass = (r_state == S_WAIT) & mem_rvalid_i & rom_ce_i
                  & (rom_addr_i[31:2] == r_req_addr);
  assign w_busy   = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_fill   = w_resp & ~r_discard & ~inval_i;
  assign w_cnt_sat = (r_miss_cnt == {CNT_W{1'b1}});

  always_comb begin
    rom_data_o = 32'h0;
    stallreq_o = 1'b0;
    if (w_hit) begin
      rom_data_o = r_last_data;
    end else if (w_bypass) begin
      rom_data_o = mem_rdata_i;
    end else if (rom_ce_i) begin
      stallreq_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rom_ce_i && !w_hit) begin
          w_state_nxt = S_REQ;
          w_latch     = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_state_nxt = S_IDLE;
          w_resp      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_addr <= 30'h0;
      r_discard  <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      if (w_latch) begin
        r_req_addr <= rom_addr_i[31:2];
        if (!w_cnt_sat) begin
          r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
      end
      // An invalidate while a fetch is in flight poisons its returning data.
      if (w_latch) begin
        r_discard <= 1'b0;
      end else if (inval_i && w_busy) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr  <= 30'h0;
      r_last_data  <= 32'h0;
      r_last_valid <= 1'b0;
    end else begin
      if (inval_i) begin
        r_last_valid <= 1'b0;
      end else if (w_fill) begin
        r_last_valid <= 1'b1;
      end
      if (w_fill) begin
        r_last_addr <= r_req_addr;
        r_last_data <= mem_rdata_i;
      end
    end
  end

  assign mem_req_o  = (r_state == S_REQ);
  assign mem_addr_o = {r_req_addr, 2'b00};
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed bench for ifetch_bridge; uses a 3-bit miss counter so saturation is reachable.
module tb_ifetch_bridge;

  localparam int TB_CNT_W = 3;

  logic                clk;
  logic                rst;
  logic                rom_ce_i;
  logic [31:0]         rom_addr_i;
  logic [31:0]         rom_data_o;
  logic                stallreq_o;
  logic                inval_i;
  logic                mem_req_o;
  logic [31:0]         mem_addr_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [31:0]         mem_rdata_i;
  logic [TB_CNT_W-1:0] miss_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  ifetch_bridge #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .stallreq_o   (stallreq_o),
    .inval_i      (inval_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .miss_cnt_o   (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full miss from IDLE: request, immediate grant, data on the following cycle.
  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = 32'h0; inval_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
    chk("rst_data", rom_data_o, 32'h0);
    chk("rst_stall_ce0", 32'(stallreq_o), 32'd0);
    rom_ce_i = 1'b1; rom_addr_i = 32'h100;
    #1;
    chk("rst_stall_ce1", 32'(stallreq_o), 32'd1);
    chk("rst_data_ce1", rom_data_o, 32'h0);
    tick(); tick();
    rst = 1'b1; rom_ce_i = 1'b0;
    tick();

    // Cold miss at 0x100
    rom_ce_i = 1'b1; rom_addr_i = 32'h100; mem_gnt_i = 1'b1;
    #1;
    chk("cold_idle_stall", 32'(stallreq_o), 32'd1);
    chk("cold_idle_req", 32'(mem_req_o), 32'd0);
    tick();
    chk("cold_req", 32'(mem_req_o), 32'd1);
    chk("cold_req_addr", mem_addr_o, 32'h100);
    chk("cold_req_stall", 32'(stallreq_o), 32'd1);
    chk("cold_miss_cnt", 32'(miss_cnt_o), 32'd1);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("cold_bypass_data", rom_data_o, 32'hDEADBEEF);
    chk("cold_bypass_stall", 32'(stallreq_o), 32'd0);
    chk("cold_wait_req", 32'(mem_req_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    chk("cold_hit_data", rom_data_o, 32'hDEADBEEF);
    chk("cold_hit_stall", 32'(stallreq_o), 32'd0);
    tick();

    // Repeated hits, byte offset ignored
    for (int i = 0; i < 10; i++) begin
      rom_addr_i = (i % 2 == 1) ? 32'h102 : 32'h100;
      #1;
      chk("rep_stall", 32'(stallreq_o), 32'd0);
      chk("rep_req", 32'(mem_req_o), 32'd0);
      chk("rep_data", rom_data_o, 32'hDEADBEEF);
      tick();
    end
    chk("rep_miss_cnt", 32'(miss_cnt_o), 32'd1);

    // Invalidate, then a miss with grant withheld five cycles
    rom_ce_i = 1'b0; inval_i = 1'b1;
    #1;
    chk("ce0_data", rom_data_o, 32'h0);
    chk("ce0_stall", 32'(stallreq_o), 32'd0);
    tick();
    inval_i = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h100;
    #1;
    chk("inval_miss_stall", 32'(stallreq_o), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req", 32'(mem_req_o), 32'd1);
      chk("hold_addr", mem_addr_o, 32'h100);
      chk("hold_stall", 32'(stallreq_o), 32'd1);
      tick();
    end
    mem_gnt_i = 1'b1;
    #1;
    chk("hold_gnt_req", 32'(mem_req_o), 32'd1);
    chk("hold_miss_cnt", 32'(miss_cnt_o), 32'd2);
    tick();

    // Core moves to 0x104 while WAIT: 0x100 still fills
    mem_gnt_i = 1'b0; rom_addr_i = 32'h104; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0100;
    #1;
    chk("chg_no_bypass_stall", 32'(stallreq_o), 32'd1);
    chk("chg_no_bypass_data", rom_data_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b0; rom_addr_i = 32'h100;
    #1;
    chk("chg_old_fill_data", rom_data_o, 32'hCAFE0100);
    chk("chg_old_fill_stall", 32'(stallreq_o), 32'd0);
    tick();
    rom_addr_i = 32'h104;
    #1;
    chk("chg_new_stall", 32'(stallreq_o), 32'd1);
    tick();
    chk("chg_new_req", 32'(mem_req_o), 32'd1);
    chk("chg_new_addr", mem_addr_o, 32'h104);
    chk("chg_miss_cnt", 32'(miss_cnt_o), 32'd3);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000104;
    #1;
    chk("chg_bypass", rom_data_o, 32'h00000104);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("chg_hit", rom_data_o, 32'h00000104);
    chk("chg_hit_stall", 32'(stallreq_o), 32'd0);
    tick();

    // Invalidate during WAIT: bypass delivers, cache stays empty
    rom_addr_i = 32'h108;
    #1;
    chk("inv_idle_stall", 32'(stallreq_o), 32'd1);
    tick();
    chk("inv_req", 32'(mem_req_o), 32'd1);
    chk("inv_miss_cnt", 32'(miss_cnt_o), 32'd4);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; inval_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    #1;
    chk("inv_bypass_data", rom_data_o, 32'h12345678);
    chk("inv_bypass_stall", 32'(stallreq_o), 32'd0);
    tick();
    inval_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    chk("inv_remiss_stall", 32'(stallreq_o), 32'd1);
    chk("inv_remiss_data", rom_data_o, 32'h0);
    tick();
    chk("inv_remiss_req", 32'(mem_req_o), 32'd1);
    chk("inv_remiss_addr", mem_addr_o, 32'h108);
    chk("inv_remiss_cnt", 32'(miss_cnt_o), 32'd5);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000108;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("inv_refill_hit", rom_data_o, 32'h00000108);
    tick();

    // Counter saturates at 7 with a 3-bit counter
    fetch_miss(32'h200, 32'hA0000200);
    fetch_miss(32'h204, 32'hA0000204);
    fetch_miss(32'h200, 32'hA0000200);
    fetch_miss(32'h204, 32'hA0000204);
    #1;
    chk("sat_miss_cnt", 32'(miss_cnt_o), 32'd7);
    chk("sat_idle_req", 32'(mem_req_o), 32'd0);
    chk("sat_hit_data", rom_data_o, 32'hA0000204);
    tick();

    // Reset mid-WAIT, stray rvalid afterwards
    rom_addr_i = 32'h300;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst = 1'b0;
    #1;
    chk("mrst_req", 32'(mem_req_o), 32'd0);
    chk("mrst_miss_cnt", 32'(miss_cnt_o), 32'd0);
    chk("mrst_stall", 32'(stallreq_o), 32'd1);
    chk("mrst_data", rom_data_o, 32'h0);
    tick();
    rst = 1'b1; rom_ce_i = 1'b0;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("stray_data", rom_data_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h300;
    #1;
    chk("post_rst_stall", 32'(stallreq_o), 32'd1);
    chk("post_rst_idle_req", 32'(mem_req_o), 32'd0);
    chk("post_rst_cnt0", 32'(miss_cnt_o), 32'd0);
    tick();
    chk("post_rst_req", 32'(mem_req_o), 32'd1);
    chk("post_rst_addr", mem_addr_o, 32'h300);
    chk("post_rst_cnt1", 32'(miss_cnt_o), 32'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
